// File: rtl/axis_mon_pkg.sv
// Shared definitions for the AXI4-Stream protocol monitor: channel FSM
// state encoding, error bit positions and the saturating increment helper.
package axis_mon_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } mon_state_e;

    localparam int ERR_VALID_DROP = 0;
    localparam int ERR_DATA_CHG   = 1;
    localparam int ERR_USER_CHG   = 2;
    localparam int ERR_TIMEOUT    = 3;

    // Increment val, holding at the all-ones value of a width-bit counter.
    // Callers cast the 64-bit result back to their counter width.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage

// File: rtl/axis_protocol_monitor_if.sv
// Bundle of NUM_CH AXI4-Stream channels (valid/ready/data/user) as seen
// on the openHMC controller ports. The monitor modport is read-only.
interface axis_protocol_monitor_if #(
    parameter int NUM_CH        = 2,
    parameter int DWIDTH        = 512,
    parameter int NUM_USER_BITS = 64
);
    logic [NUM_CH-1:0]               ch_tvalid;
    logic [NUM_CH-1:0]               ch_tready;
    logic [NUM_CH*DWIDTH-1:0]        ch_tdata;
    logic [NUM_CH*NUM_USER_BITS-1:0] ch_tuser;

    modport master (output ch_tvalid, output ch_tdata, output ch_tuser, input ch_tready);
    modport slave  (input ch_tvalid, input ch_tdata, input ch_tuser, output ch_tready);
    modport monitor(input ch_tvalid, input ch_tready, input ch_tdata, input ch_tuser);
endinterface

// File: rtl/axis_mon_channel.sv
// One monitored AXI4-Stream channel: IDLE/STALL FSM, stall timer, payload
// capture, sticky error bits and saturating transfer/error counters.
// Payload capture and compare exist only with AXIS_MON_PAYLOAD_CHECK_EN.
module axis_mon_channel
    import axis_mon_pkg::*;
#(
    parameter int DWIDTH        = 512,
    parameter int NUM_USER_BITS = 64,
    parameter int CNT_W         = 32,
    parameter int STALL_W       = 12
) (
    input  logic                     clk_hmc,
    input  logic                     res_n_hmc,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [STALL_W-1:0]       stall_limit,
    input  logic                     tvalid,
    input  logic                     tready,
`ifdef AXIS_MON_PAYLOAD_CHECK_EN
    input  logic [DWIDTH-1:0]        tdata,
    input  logic [NUM_USER_BITS-1:0] tuser,
`endif
    output logic [3:0]               new_err,
    output logic [3:0]               err_sticky,
    output logic [CNT_W-1:0]         xfer_cnt,
    output logic [CNT_W-1:0]         err_cnt
);

    mon_state_e           state_reg, state_next;
    logic [STALL_W-1:0]   stall_cnt_reg, stall_cnt_next, cnt_cur;
    logic                 tmo_rep_reg, tmo_rep_next;
    logic                 stall_hit, xfer_inc;
    logic [3:0]           sticky_reg;
    logic [CNT_W-1:0]     xfer_cnt_reg, err_cnt_reg;

`ifdef AXIS_MON_PAYLOAD_CHECK_EN
    logic [DWIDTH-1:0]        cap_data_reg;
    logic [NUM_USER_BITS-1:0] cap_user_reg;
    logic                     data_rep_reg, data_rep_next;
    logic                     user_rep_reg, user_rep_next;
    logic                     cap_load;
`endif

    // cnt_cur is the 1-based index of the current stall cycle.
    assign cnt_cur   = (state_reg == IDLE) ? STALL_W'(1)
                                           : STALL_W'(sat_inc(64'(stall_cnt_reg), STALL_W));
    assign stall_hit = (stall_limit != '0) && (cnt_cur == stall_limit);

    // Next-state, error detection and transfer detection for this cycle.
    always_comb begin
        state_next     = state_reg;
        stall_cnt_next = stall_cnt_reg;
        tmo_rep_next   = tmo_rep_reg;
        new_err        = 4'b0000;
        xfer_inc       = 1'b0;
`ifdef AXIS_MON_PAYLOAD_CHECK_EN
        data_rep_next  = data_rep_reg;
        user_rep_next  = user_rep_reg;
        cap_load       = 1'b0;
`endif
        if (!enable) begin
            state_next     = IDLE;
            stall_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (tvalid && tready) begin
                        xfer_inc = 1'b1;
                    end else if (tvalid) begin
                        state_next             = STALL;
                        stall_cnt_next         = cnt_cur;
                        tmo_rep_next           = stall_hit;
                        new_err[ERR_TIMEOUT]   = stall_hit;
`ifdef AXIS_MON_PAYLOAD_CHECK_EN
                        cap_load      = 1'b1;
                        data_rep_next = 1'b0;
                        user_rep_next = 1'b0;
`endif
                    end
                end
                STALL: begin
                    if (!tvalid) begin
                        new_err[ERR_VALID_DROP] = 1'b1;
                        state_next              = IDLE;
                        stall_cnt_next          = '0;
                    end else begin
`ifdef AXIS_MON_PAYLOAD_CHECK_EN
                        if ((tdata != cap_data_reg) && !data_rep_reg) begin
                            new_err[ERR_DATA_CHG] = 1'b1;
                            data_rep_next         = 1'b1;
                        end
                        if ((tuser != cap_user_reg) && !user_rep_reg) begin
                            new_err[ERR_USER_CHG] = 1'b1;
                            user_rep_next         = 1'b1;
                        end
`endif
                        if (tready) begin
                            xfer_inc       = 1'b1;
                            state_next     = IDLE;
                            stall_cnt_next = '0;
                        end else begin
                            stall_cnt_next = cnt_cur;
                            if (stall_hit && !tmo_rep_reg) begin
                                new_err[ERR_TIMEOUT] = 1'b1;
                                tmo_rep_next         = 1'b1;
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, stall timer, sticky bits and counters; clear beats any event.
    always_ff @(posedge clk_hmc) begin
        if (!res_n_hmc || clear) begin
            state_reg     <= IDLE;
            stall_cnt_reg <= '0;
            tmo_rep_reg   <= 1'b0;
            sticky_reg    <= 4'b0000;
            xfer_cnt_reg  <= '0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            stall_cnt_reg <= stall_cnt_next;
            tmo_rep_reg   <= tmo_rep_next;
            sticky_reg    <= sticky_reg | new_err;
            if (xfer_inc)
                xfer_cnt_reg <= CNT_W'(sat_inc(64'(xfer_cnt_reg), CNT_W));
            if (|new_err)
                err_cnt_reg <= CNT_W'(sat_inc(64'(err_cnt_reg), CNT_W));
        end
    end

`ifdef AXIS_MON_PAYLOAD_CHECK_EN
    // Payload snapshot taken on the first stalled cycle and held for the stall.
    always_ff @(posedge clk_hmc) begin
        if (!res_n_hmc || clear) begin
            cap_data_reg <= '0;
            cap_user_reg <= '0;
            data_rep_reg <= 1'b0;
            user_rep_reg <= 1'b0;
        end else begin
            data_rep_reg <= data_rep_next;
            user_rep_reg <= user_rep_next;
            if (cap_load) begin
                cap_data_reg <= tdata;
                cap_user_reg <= tuser;
            end
        end
    end
`endif

    assign err_sticky = sticky_reg;
    assign xfer_cnt   = xfer_cnt_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: rtl/axis_protocol_monitor.sv
// Passive multi-channel AXI4-Stream protocol monitor. Instantiates one
// axis_mon_channel per channel and owns err_any plus first-error capture.
// Optional payload-stability checks: define AXIS_MON_PAYLOAD_CHECK_EN.
module axis_protocol_monitor
    import axis_mon_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int DWIDTH        = 512,
    parameter int NUM_USER_BITS = 64,
    parameter int CNT_W         = 32,
    parameter int STALL_W       = 12,
    localparam int FCH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk_hmc,
    input  logic                      res_n_hmc,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [STALL_W-1:0]        stall_limit,
    axis_protocol_monitor_if.monitor  bus,
    output logic [NUM_CH*4-1:0]       err_sticky,
    output logic                      err_any,
    output logic                      first_err_valid,
    output logic [FCH_W-1:0]          first_err_ch,
    output logic [3:0]                first_err_code,
    output logic [NUM_CH*CNT_W-1:0]   xfer_cnt,
    output logic [NUM_CH*CNT_W-1:0]   err_cnt
);

    logic [3:0]       ch_new_err [NUM_CH];
    logic             cap_hit;
    logic [FCH_W-1:0] cap_ch;
    logic [3:0]       cap_code;
    logic             fe_valid_reg;
    logic [FCH_W-1:0] fe_ch_reg;
    logic [3:0]       fe_code_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            axis_mon_channel #(
                .DWIDTH        (DWIDTH),
                .NUM_USER_BITS (NUM_USER_BITS),
                .CNT_W         (CNT_W),
                .STALL_W       (STALL_W)
            ) u_ch (
                .clk_hmc     (clk_hmc),
                .res_n_hmc   (res_n_hmc),
                .enable      (enable),
                .clear       (clear),
                .stall_limit (stall_limit),
                .tvalid      (bus.ch_tvalid[gi]),
                .tready      (bus.ch_tready[gi]),
`ifdef AXIS_MON_PAYLOAD_CHECK_EN
                .tdata       (bus.ch_tdata[gi*DWIDTH +: DWIDTH]),
                .tuser       (bus.ch_tuser[gi*NUM_USER_BITS +: NUM_USER_BITS]),
`endif
                .new_err     (ch_new_err[gi]),
                .err_sticky  (err_sticky[gi*4 +: 4]),
                .xfer_cnt    (xfer_cnt[gi*CNT_W +: CNT_W]),
                .err_cnt     (err_cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // Lowest-indexed channel with a new error this cycle wins the capture.
    always_comb begin
        cap_hit  = 1'b0;
        cap_ch   = '0;
        cap_code = 4'b0000;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (|ch_new_err[i]) begin
                cap_hit  = 1'b1;
                cap_ch   = FCH_W'(i);
                cap_code = ch_new_err[i];
            end
        end
    end

    // First-error capture register, frozen once valid until clear/reset.
    always_ff @(posedge clk_hmc) begin
        if (!res_n_hmc || clear) begin
            fe_valid_reg <= 1'b0;
            fe_ch_reg    <= '0;
            fe_code_reg  <= 4'b0000;
        end else if (!fe_valid_reg && cap_hit) begin
            fe_valid_reg <= 1'b1;
            fe_ch_reg    <= cap_ch;
            fe_code_reg  <= cap_code;
        end
    end

    assign err_any         = |err_sticky;
    assign first_err_valid = fe_valid_reg;
    assign first_err_ch    = fe_ch_reg;
    assign first_err_code  = fe_code_reg;

endmodule

// File: tb/tb_axis_protocol_monitor.sv
// Self-checking bench for axis_protocol_monitor: directed scenarios then a
// randomized run, all compared against a transaction-level reference model.
module tb_axis_protocol_monitor;

    localparam int NCH = 2;
    localparam int DW  = 64;
    localparam int UW  = 8;
    localparam int CW  = 4;
    localparam int SW  = 12;
    localparam int CMAX = (1 << CW) - 1;
    localparam int SMAX = (1 << SW) - 1;
`ifdef AXIS_MON_PAYLOAD_CHECK_EN
    localparam bit PAY = 1'b1;
`else
    localparam bit PAY = 1'b0;
`endif

    logic              clk_hmc = 1'b0;
    logic              res_n_hmc;
    logic              enable;
    logic              clear;
    logic [SW-1:0]     stall_limit;
    logic [NCH*4-1:0]  err_sticky;
    logic              err_any;
    logic              first_err_valid;
    logic [0:0]        first_err_ch;
    logic [3:0]        first_err_code;
    logic [NCH*CW-1:0] xfer_cnt;
    logic [NCH*CW-1:0] err_cnt;

    axis_protocol_monitor_if #(.NUM_CH(NCH), .DWIDTH(DW), .NUM_USER_BITS(UW)) bus ();

    axis_protocol_monitor #(
        .NUM_CH(NCH), .DWIDTH(DW), .NUM_USER_BITS(UW), .CNT_W(CW), .STALL_W(SW)
    ) dut (
        .clk_hmc(clk_hmc), .res_n_hmc(res_n_hmc), .enable(enable), .clear(clear),
        .stall_limit(stall_limit), .bus(bus),
        .err_sticky(err_sticky), .err_any(err_any), .first_err_valid(first_err_valid),
        .first_err_ch(first_err_ch), .first_err_code(first_err_code),
        .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
    );

    always #5 clk_hmc = ~clk_hmc;

    int errors = 0;
    int checks = 0;
    bit verbose = 1'b1;
    int cyc = 0;

    // Reference model: per channel, is a beat pending and for how many cycles.
    bit          m_pending [NCH];
    int          m_wait    [NCH];
    logic [DW-1:0] m_capd  [NCH];
    logic [UW-1:0] m_capu  [NCH];
    bit          m_rep_d [NCH], m_rep_u [NCH], m_rep_t [NCH];
    logic [3:0]  m_sticky [NCH];
    int          m_xfer [NCH], m_errc [NCH];
    bit          m_fv;
    int          m_fch;
    logic [3:0]  m_fcode;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pending[c] = 0; m_wait[c] = 0; m_capd[c] = '0; m_capu[c] = '0;
            m_rep_d[c] = 0; m_rep_u[c] = 0; m_rep_t[c] = 0;
            m_sticky[c] = 4'b0; m_xfer[c] = 0; m_errc[c] = 0;
        end
        m_fv = 0; m_fch = 0; m_fcode = 4'b0;
    endtask

    // Apply the rules to the inputs present at the coming clock edge.
    task automatic model_step();
        logic [3:0] ne [NCH];
        bit v, r;
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        int lim;
        if (!res_n_hmc || clear) begin
            model_reset();
            return;
        end
        if (!enable) begin
            for (int c = 0; c < NCH; c++) m_pending[c] = 0;
            return;
        end
        lim = int'(stall_limit);
        for (int c = 0; c < NCH; c++) begin
            ne[c] = 4'b0;
            v = bus.ch_tvalid[c];
            r = bus.ch_tready[c];
            d = bus.ch_tdata[c*DW +: DW];
            u = bus.ch_tuser[c*UW +: UW];
            if (m_pending[c] && !v) begin
                ne[c][0] = 1'b1;
                m_pending[c] = 0;
            end else if (v) begin
                if (!m_pending[c]) begin
                    m_capd[c] = d; m_capu[c] = u;
                    m_rep_d[c] = 0; m_rep_u[c] = 0; m_rep_t[c] = 0;
                    m_wait[c] = 1;
                end else begin
                    if (PAY && d != m_capd[c] && !m_rep_d[c]) begin ne[c][1] = 1'b1; m_rep_d[c] = 1; end
                    if (PAY && u != m_capu[c] && !m_rep_u[c]) begin ne[c][2] = 1'b1; m_rep_u[c] = 1; end
                    m_wait[c] = (m_wait[c] >= SMAX) ? SMAX : m_wait[c] + 1;
                end
                if (r) begin
                    m_xfer[c] = (m_xfer[c] >= CMAX) ? CMAX : m_xfer[c] + 1;
                    m_pending[c] = 0;
                end else begin
                    if (lim != 0 && m_wait[c] == lim && !m_rep_t[c]) begin
                        ne[c][3] = 1'b1; m_rep_t[c] = 1;
                    end
                    m_pending[c] = 1;
                end
            end
            m_sticky[c] |= ne[c];
            if (ne[c] != 0) m_errc[c] = (m_errc[c] >= CMAX) ? CMAX : m_errc[c] + 1;
        end
        if (!m_fv) begin
            for (int c = 0; c < NCH; c++) begin
                if (!m_fv && ne[c] != 0) begin
                    m_fv = 1; m_fch = c; m_fcode = ne[c];
                end
            end
        end
    endtask

    task automatic check_all();
        logic [NCH*4-1:0]  es;
        logic [NCH*CW-1:0] ex, ee;
        bit ea;
        ea = 0;
        for (int c = 0; c < NCH; c++) begin
            es[c*4 +: 4]   = m_sticky[c];
            ex[c*CW +: CW] = CW'(m_xfer[c]);
            ee[c*CW +: CW] = CW'(m_errc[c]);
            if (m_sticky[c] != 0) ea = 1;
        end
        chk("err_sticky", 64'(err_sticky), 64'(es));
        chk("err_any", 64'(err_any), 64'(ea));
        chk("first_err_valid", 64'(first_err_valid), 64'(m_fv));
        chk("first_err_ch", 64'(first_err_ch), 64'(m_fv ? m_fch : 0));
        chk("first_err_code", 64'(first_err_code), 64'(m_fcode));
        chk("xfer_cnt", 64'(xfer_cnt), 64'(ex));
        chk("err_cnt", 64'(err_cnt), 64'(ee));
    endtask

    // One bus cycle: model the edge, let the DUT register it, compare.
    task automatic cycle(input string note);
        model_step();
        @(posedge clk_hmc);
        #1;
        cyc++;
        if (verbose)
            $display("cyc %0d %s v=%b r=%b en=%b clr=%b lim=%0d sticky=%h xfer=%h errc=%h fe=%b/%0d/%b",
                     cyc, note, bus.ch_tvalid, bus.ch_tready, enable, clear, stall_limit,
                     err_sticky, xfer_cnt, err_cnt, first_err_valid, first_err_ch, first_err_code);
        check_all();
    endtask

    task automatic set_ch(input int c, input bit v, input bit r, input logic [DW-1:0] d, input logic [UW-1:0] u);
        bus.ch_tvalid[c] = v;
        bus.ch_tready[c] = r;
        bus.ch_tdata[c*DW +: DW] = d;
        bus.ch_tuser[c*UW +: UW] = u;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; cycle("clear"); clear = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rd [NCH];
        logic [UW-1:0] ru [NCH];
        model_reset();
        res_n_hmc = 1'b0; enable = 1'b0; clear = 1'b0; stall_limit = '0;
        bus.ch_tvalid = '0; bus.ch_tready = '0; bus.ch_tdata = '0; bus.ch_tuser = '0;

        // Reset state
        cycle("reset"); cycle("reset");
        chk("reset_sticky", 64'(err_sticky), 64'd0);
        chk("reset_xfer", 64'(xfer_cnt), 64'd0);
        res_n_hmc = 1'b1; enable = 1'b1;

        // Ch0: ten back-to-back transfers
        set_ch(0, 1, 1, 64'h11, 8'h1);
        for (int i = 0; i < 10; i++) cycle("ch0 xfer");
        set_ch(0, 0, 0, 64'h0, 8'h0);
        cycle("idle");
        chk("t1_xfer0", 64'(xfer_cnt[CW-1:0]), 64'd10);
        chk("t1_err_any", 64'(err_any), 64'd0);

        // Ch1: stalled three cycles, then valid drops
        set_ch(1, 1, 0, 64'h22, 8'h2);
        for (int i = 0; i < 3; i++) cycle("ch1 stall");
        set_ch(1, 0, 0, 64'h0, 8'h0);
        cycle("ch1 drop");
        chk("t2_sticky1", 64'(err_sticky[7:4]), 64'h1);
        chk("t2_errc1", 64'(err_cnt[2*CW-1:CW]), 64'd1);
        chk("t2_fe_ch", 64'(first_err_ch), 64'd1);
        chk("t2_fe_code", 64'(first_err_code), 64'h1);
        pulse_clear();

        // Ch0: payload changes twice within one stall
        set_ch(0, 1, 0, {8{8'hA5}}, 8'h3);
        cycle("ch0 stall");
        set_ch(0, 1, 0, {8{8'h5A}}, 8'h3);
        cycle("ch0 data chg");
        set_ch(0, 1, 0, {8{8'h3C}}, 8'h3);
        cycle("ch0 data chg2");
        set_ch(0, 1, 1, {8{8'h3C}}, 8'h3);
        cycle("ch0 accept");
        set_ch(0, 0, 0, 64'h0, 8'h0);
        cycle("idle");
        chk("t3_errc0", 64'(err_cnt[CW-1:0]), PAY ? 64'd1 : 64'd0);
        chk("t3_sticky0", 64'(err_sticky[3:0]), PAY ? 64'h2 : 64'h0);
        chk("t3_xfer0", 64'(xfer_cnt[CW-1:0]), 64'd1);
        pulse_clear();

        // Stall timeout at limit 5
        stall_limit = 12'd5;
        set_ch(0, 1, 0, 64'h77, 8'h7);
        for (int k = 1; k <= 8; k++) begin
            cycle("ch0 tmo stall");
            chk("t4_tmo_bit", 64'(err_sticky[3]), (k >= 5) ? 64'd1 : 64'd0);
        end
        set_ch(0, 1, 1, 64'h77, 8'h7);
        cycle("ch0 accept");
        chk("t4_errc0", 64'(err_cnt[CW-1:0]), 64'd1);
        set_ch(0, 0, 0, 64'h0, 8'h0);
        pulse_clear();
        stall_limit = '0;
        set_ch(0, 1, 0, 64'h77, 8'h7);
        for (int k = 0; k < 8; k++) cycle("ch0 no tmo");
        set_ch(0, 1, 1, 64'h77, 8'h7);
        cycle("ch0 accept");
        set_ch(0, 0, 0, 64'h0, 8'h0);
        chk("t4_no_err", 64'(err_any), 64'd0);
        pulse_clear();

        // Simultaneous ch0 VALID_DROP and ch1 TIMEOUT, then clear vs new error
        stall_limit = 12'd3;
        set_ch(0, 1, 0, 64'h1, 8'h1);
        set_ch(1, 1, 0, 64'h2, 8'h2);
        cycle("both stall"); cycle("both stall");
        set_ch(0, 0, 0, 64'h0, 8'h0);
        cycle("ch0 drop ch1 tmo");
        chk("t5_fe_ch", 64'(first_err_ch), 64'd0);
        chk("t5_fe_code", 64'(first_err_code), 64'h1);
        chk("t5_sticky", 64'(err_sticky), 64'h81);
        set_ch(1, 0, 0, 64'h0, 8'h0);
        clear = 1'b1;
        cycle("clear + ch1 drop");
        clear = 1'b0;
        chk("t5_cleared", 64'({err_sticky, err_any, first_err_valid, xfer_cnt, err_cnt}), 64'd0);
        stall_limit = '0;

        // Counter saturation, then reset mid-stall
        set_ch(0, 1, 1, 64'h9, 8'h9);
        for (int i = 0; i < 20; i++) cycle("ch0 xfer");
        chk("t6_sat", 64'(xfer_cnt[CW-1:0]), 64'd15);
        set_ch(0, 1, 0, 64'h9, 8'h9);
        cycle("ch0 stall"); cycle("ch0 stall");
        res_n_hmc = 1'b0;
        cycle("reset mid-stall");
        chk("t6_reset", 64'({err_sticky, first_err_valid, xfer_cnt, err_cnt}), 64'd0);
        res_n_hmc = 1'b1;
        set_ch(0, 0, 0, 64'h0, 8'h0);
        cycle("after reset"); cycle("after reset");
        chk("t6_no_drop", 64'(err_any), 64'd0);

        // Disable mid-stall, re-enable with valid low: no VALID_DROP
        set_ch(1, 1, 0, 64'h5, 8'h5);
        cycle("ch1 stall"); cycle("ch1 stall");
        enable = 1'b0;
        cycle("disabled");
        set_ch(1, 0, 0, 64'h0, 8'h0);
        enable = 1'b1;
        cycle("reenabled");
        chk("t7_no_drop", 64'(err_any), 64'd0);

        // Randomized traffic against the model
        verbose = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            rd[c] = {$urandom, $urandom}; ru[c] = 8'($urandom);
        end
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 4))
                    0: stall_limit = 12'd0;
                    1: stall_limit = 12'd1;
                    2: stall_limit = 12'd2;
                    3: stall_limit = 12'd3;
                    default: stall_limit = 12'd6;
                endcase
            end
            clear  = ($urandom_range(0, 59) == 0);
            enable = ($urandom_range(0, 29) != 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 7) == 0) rd[c] = {$urandom, $urandom};
                if ($urandom_range(0, 9) == 0) ru[c] = 8'($urandom);
                set_ch(c, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, rd[c], ru[c]);
            end
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
